// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
interface mem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: IDLE/BUSY/DONE handshake with a variable-latency data memory.
// Optional BUSY timeout abort is enabled by defining MEM_TIMEOUT_EN.
module mem_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        regwrite_in,
    input  logic        memtoreg_in,
    input  logic        memread_in,
    input  logic        memwrite_in,
    input  logic [31:0] alures_in,
    input  logic [31:0] read_data_2_in,
    input  logic [4:0]  mux_1_in,
    mem_access_if.master dmem,
    output logic        mem_stall,
    output logic        regwrite_out,
    output logic        memtoreg_out,
    output logic [31:0] mem_data_out,
    output logic [31:0] alures_out,
    output logic [4:0]  mux_1_out,
    output logic        misalign_err,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic        mem_op, aligned, issue, ack_hit, tmo_hit, tmo_q;

    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        h_regwrite_q, h_memtoreg_q, h_memread_q;
    logic [31:0] h_alures_q;
    logic [4:0]  h_mux_q;

    logic        wb_regwrite_d, wb_memtoreg_d, wb_misalign_d, wb_timeout_d;
    logic [31:0] wb_data_d, wb_alures_d;
    logic [4:0]  wb_mux_d;
    logic        wb_regwrite_q, wb_memtoreg_q, wb_misalign_q, wb_timeout_q;
    logic [31:0] wb_data_q, wb_alures_q;
    logic [4:0]  wb_mux_q;

    assign mem_op  = memread_in | memwrite_in;
    assign aligned = (alures_in[1:0] == 2'b00);
    assign issue   = (state_q == IDLE) && mem_op && aligned;
    assign ack_hit = (state_q == BUSY) && dmem.dmem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;
    assign tmo_hit = (state_q == BUSY) && !dmem.dmem_ack && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else if (issue) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else if (state_q == BUSY && !dmem.dmem_ack) begin
            cnt_q <= cnt_inc;
            tmo_q <= tmo_hit;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo_q   = 1'b0;
`endif

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = BUSY;
            BUSY:    if (ack_hit || tmo_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Anything other than a completing op or a non-issuing IDLE op writes a bubble.
    always_comb begin
        mem_stall     = reset & (issue | (state_q == BUSY));
        wb_regwrite_d = 1'b0;
        wb_memtoreg_d = 1'b0;
        wb_misalign_d = 1'b0;
        wb_timeout_d  = 1'b0;
        wb_data_d     = '0;
        wb_alures_d   = '0;
        wb_mux_d      = '0;
        case (state_q)
            IDLE: if (!mem_op || !aligned) begin
                wb_regwrite_d = regwrite_in & ~mem_op;
                wb_memtoreg_d = memtoreg_in;
                wb_alures_d   = alures_in;
                wb_mux_d      = mux_1_in;
                wb_misalign_d = mem_op;
            end
            DONE: begin
                wb_regwrite_d = h_regwrite_q & ~tmo_q;
                wb_memtoreg_d = h_memtoreg_q;
                wb_alures_d   = h_alures_q;
                wb_mux_d      = h_mux_q;
                wb_data_d     = (h_memread_q && !tmo_q) ? rdata_q : 32'h0;
                wb_timeout_d  = tmo_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            h_regwrite_q <= 1'b0;
            h_memtoreg_q <= 1'b0;
            h_memread_q  <= 1'b0;
            h_alures_q   <= '0;
            h_mux_q      <= '0;
        end else if (issue) begin
            req_q        <= 1'b1;
            we_q         <= memwrite_in;
            addr_q       <= alures_in;
            wdata_q      <= read_data_2_in;
            h_regwrite_q <= regwrite_in;
            h_memtoreg_q <= memtoreg_in;
            h_memread_q  <= memread_in;
            h_alures_q   <= alures_in;
            h_mux_q      <= mux_1_in;
        end else if (ack_hit || tmo_hit) begin
            req_q <= 1'b0;
            if (ack_hit) rdata_q <= dmem.dmem_rdata;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_misalign_q <= 1'b0;
            wb_timeout_q  <= 1'b0;
            wb_data_q     <= '0;
            wb_alures_q   <= '0;
            wb_mux_q      <= '0;
        end else begin
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            wb_misalign_q <= wb_misalign_d;
            wb_timeout_q  <= wb_timeout_d;
            wb_data_q     <= wb_data_d;
            wb_alures_q   <= wb_alures_d;
            wb_mux_q      <= wb_mux_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    assign regwrite_out = wb_regwrite_q;
    assign memtoreg_out = wb_memtoreg_q;
    assign mem_data_out = wb_data_q;
    assign alures_out   = wb_alures_q;
    assign mux_1_out    = wb_mux_q;
    assign misalign_err = wb_misalign_q;
    assign timeout_err  = wb_timeout_q;
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, load, store, misalign, reset mid-BUSY, timeout.
module tb_mem_access;
    logic        Clk, reset;
    logic        regwrite_in, memtoreg_in, memread_in, memwrite_in;
    logic [31:0] alures_in, read_data_2_in;
    logic [4:0]  mux_1_in;
    logic        mem_stall, regwrite_out, memtoreg_out, misalign_err, timeout_err;
    logic [31:0] mem_data_out, alures_out;
    logic [4:0]  mux_1_out;
    int          n_cmp = 0;
    int          n_err = 0;

    mem_access_if dm();

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .Clk(Clk), .reset(reset),
        .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
        .memread_in(memread_in), .memwrite_in(memwrite_in),
        .alures_in(alures_in), .read_data_2_in(read_data_2_in), .mux_1_in(mux_1_in),
        .dmem(dm),
        .mem_stall(mem_stall), .regwrite_out(regwrite_out), .memtoreg_out(memtoreg_out),
        .mem_data_out(mem_data_out), .alures_out(alures_out), .mux_1_out(mux_1_out),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic sett;
        #3;
    endtask

    task automatic drv(input logic rw, input logic mtr, input logic mr, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
        regwrite_in    = rw;
        memtoreg_in    = mtr;
        memread_in     = mr;
        memwrite_in    = mw;
        alures_in      = alu;
        read_data_2_in = wd;
        mux_1_in       = rd;
    endtask

    initial begin
        reset = 1'b0;
        dm.dmem_ack   = 1'b0;
        dm.dmem_rdata = '0;
        drv(1, 1, 1, 0, 32'h100, 0, 2);
        #12;
        chk("rst_req",   dm.dmem_req, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_rw",    regwrite_out, 0);
        chk("rst_data",  mem_data_out, 0);
        drv(0, 0, 0, 0, 0, 0, 0);

        // ALU op
        tick; reset = 1'b1;
        drv(1, 0, 0, 0, 32'h10, 0, 5);
        sett;
        chk("alu_stall0", mem_stall, 0);
        tick; drv(0, 0, 0, 0, 0, 0, 0); sett;
        chk("alu_res",   alures_out, 32'h10);
        chk("alu_rw",    regwrite_out, 1);
        chk("alu_rd",    mux_1_out, 5);
        chk("alu_data",  mem_data_out, 0);
        chk("alu_stall1", mem_stall, 0);

        // Load, ack in the second BUSY cycle
        tick; drv(1, 1, 1, 0, 32'h100, 0, 7); sett;
        chk("ld_stall_a", mem_stall, 1);
        chk("ld_req_a",   dm.dmem_req, 0);
        tick; sett;
        chk("ld_req_b",   dm.dmem_req, 1);
        chk("ld_addr",    dm.dmem_addr, 32'h100);
        chk("ld_we",      dm.dmem_we, 0);
        chk("ld_stall_b", mem_stall, 1);
        chk("ld_bubble1", regwrite_out, 0);
        tick; dm.dmem_ack = 1'b1; dm.dmem_rdata = 32'hDEAD_BEEF; sett;
        chk("ld_req_c",   dm.dmem_req, 1);
        chk("ld_stall_c", mem_stall, 1);
        tick; dm.dmem_ack = 1'b0; dm.dmem_rdata = '0; sett;
        chk("ld_req_d",   dm.dmem_req, 0);
        chk("ld_stall_d", mem_stall, 0);
        chk("ld_bubble2", regwrite_out, 0);
        chk("ld_bubble3", mem_data_out, 0);
        tick; drv(0, 0, 0, 0, 0, 0, 0); sett;
        chk("ld_data",    mem_data_out, 32'hDEAD_BEEF);
        chk("ld_mtr",     memtoreg_out, 1);
        chk("ld_rw",      regwrite_out, 1);
        chk("ld_rd",      mux_1_out, 7);

        // Store, write data must stay latched while BUSY
        tick; drv(0, 0, 0, 1, 32'h200, 32'h1234_5678, 9); sett;
        chk("st_stall",   mem_stall, 1);
        tick; read_data_2_in = 32'hFFFF_FFFF; sett;
        chk("st_we",      dm.dmem_we, 1);
        chk("st_wdata_a", dm.dmem_wdata, 32'h1234_5678);
        chk("st_addr",    dm.dmem_addr, 32'h200);
        chk("st_req",     dm.dmem_req, 1);
        tick; dm.dmem_ack = 1'b1; sett;
        chk("st_wdata_b", dm.dmem_wdata, 32'h1234_5678);
        tick; dm.dmem_ack = 1'b0; sett;
        chk("st_req_off", dm.dmem_req, 0);
        tick; drv(0, 0, 0, 0, 0, 0, 0); sett;
        chk("st_rw",      regwrite_out, 0);
        chk("st_data",    mem_data_out, 0);
        chk("st_alu",     alures_out, 32'h200);

        // Misaligned load
        tick; drv(1, 1, 1, 0, 32'h102, 0, 3); sett;
        chk("mis_stall",  mem_stall, 0);
        chk("mis_req_a",  dm.dmem_req, 0);
        tick; drv(0, 0, 0, 0, 0, 0, 0); sett;
        chk("mis_err",    misalign_err, 1);
        chk("mis_rw",     regwrite_out, 0);
        chk("mis_req_b",  dm.dmem_req, 0);
        chk("mis_alu",    alures_out, 32'h102);
        tick; sett;
        chk("mis_err_end", misalign_err, 0);

        // Reset asserted in BUSY abandons the request immediately
        tick; drv(1, 1, 1, 0, 32'h300, 0, 4); sett;
        tick; sett;
        chk("rb_req_on",  dm.dmem_req, 1);
        #1 reset = 1'b0;
        #1;
        chk("rb_req_off", dm.dmem_req, 0);
        chk("rb_stall",   mem_stall, 0);
        chk("rb_rw",      regwrite_out, 0);
        tick; tick;
        reset = 1'b1;
        drv(1, 1, 1, 0, 32'h400, 0, 6); sett;
        chk("rb2_stall",  mem_stall, 1);
        tick; dm.dmem_ack = 1'b1; dm.dmem_rdata = 32'hCAFE_F00D; sett;
        chk("rb2_req",    dm.dmem_req, 1);
        chk("rb2_addr",   dm.dmem_addr, 32'h400);
        tick; dm.dmem_ack = 1'b0; dm.dmem_rdata = '0; sett;
        chk("rb2_done",   dm.dmem_req, 0);
        tick; drv(0, 0, 0, 0, 0, 0, 0); sett;
        chk("rb2_data",   mem_data_out, 32'hCAFE_F00D);
        chk("rb2_rw",     regwrite_out, 1);
        chk("rb2_rd",     mux_1_out, 6);

`ifdef MEM_TIMEOUT_EN
        // No ack: request dropped after 4 BUSY cycles
        tick; drv(1, 1, 1, 0, 32'h500, 0, 8); sett;
        for (int i = 0; i < 4; i++) begin
            tick; sett;
            chk($sformatf("to_req%0d", i), dm.dmem_req, 1);
        end
        tick; sett;
        chk("to_req_off", dm.dmem_req, 0);
        chk("to_pend",    timeout_err, 0);
        tick; drv(0, 0, 0, 0, 0, 0, 0); sett;
        chk("to_err",     timeout_err, 1);
        chk("to_rw",      regwrite_out, 0);
        tick; sett;
        chk("to_err_end", timeout_err, 0);
`else
        tick; sett;
        chk("to_tied",    timeout_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
